// File: rtl/pc_sequencer.sv
// Program-counter sequencer with BOOT/RUN/HALT FSM and a return-address stack.
// Latency: one cycle from a control input to the pc update; RAS commits on the same edge.
// Backpressure: stall holds pc, the RAS, the FSM state and the error flags indefinitely.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   pc, pc_plus1     registered PC out; incrementer result for pc back in (combinational)
//   fetch_valid      pc is a valid fetch address (RUN state only)
//   stall, halt, resume                  pipeline hold / enter HALT / leave HALT
//   branch_taken, branch_target          conditional redirect
//   jump, call, jump_target, ret         unconditional redirect, call (push), return (pop)
//   ras_overflow, ras_underflow          sticky RAS error flags, cleared only by reset
module pc_sequencer #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_plus1,
    output logic             fetch_valid,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret,
    input  logic             halt,
    input  logic             resume,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int IW = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_fetch_valid;
    logic             r_ras_ovf;
    logic             r_ras_unf;
    logic [CW-1:0]    r_ras_cnt;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];

    logic             w_ras_full;
    logic             w_ras_empty;
    logic             w_act;
    logic             w_push;
    logic             w_pop;
    logic [IW-1:0]    w_top_idx;
    logic [IW-1:0]    w_push_idx;

    assign w_ras_full  = (r_ras_cnt == CW'(RAS_DEPTH));
    assign w_ras_empty = (r_ras_cnt == '0);

    // A control below halt in the priority order only acts in RUN with no stall/halt.
    assign w_act      = (r_state == S_RUN) && !stall && !halt;
    assign w_pop      = w_act && ret;
    assign w_push     = w_act && !ret && call;
    assign w_top_idx  = IW'(r_ras_cnt - 1'b1);
    assign w_push_idx = IW'(r_ras_cnt);

    // Entry storage needs no reset: entries are only read below the count, and the
    // count is cleared by reset, which also suppresses w_push via r_state.
    always_ff @(posedge clk) begin
        if (w_push) begin
            if (w_ras_full) begin
                // Full: slide everything down, dropping the oldest return address.
                for (int i = 0; i < RAS_DEPTH - 1; i++) begin
                    r_ras[i] <= r_ras[i+1];
                end
                r_ras[RAS_DEPTH-1] <= pc_plus1;
            end else begin
                r_ras[w_push_idx] <= pc_plus1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_pc          <= WIDTH'(RESET_PC);
            r_fetch_valid <= 1'b0;
            r_ras_ovf     <= 1'b0;
            r_ras_unf     <= 1'b0;
            r_ras_cnt     <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state       <= S_RUN;
                    r_fetch_valid <= 1'b1;
                end
                S_RUN: begin
                    if (stall) begin
                        // hold everything
                    end else if (halt) begin
                        r_state       <= S_HALT;
                        r_fetch_valid <= 1'b0;
                    end else if (w_pop) begin
                        if (w_ras_empty) begin
                            r_ras_unf <= 1'b1;
                            r_pc      <= pc_plus1;
                        end else begin
                            r_pc      <= r_ras[w_top_idx];
                            r_ras_cnt <= r_ras_cnt - 1'b1;
                        end
                    end else if (w_push) begin
                        r_pc <= jump_target;
                        if (w_ras_full) begin
                            r_ras_ovf <= 1'b1;
                        end else begin
                            r_ras_cnt <= r_ras_cnt + 1'b1;
                        end
                    end else if (jump) begin
                        r_pc <= jump_target;
                    end else if (branch_taken) begin
                        r_pc <= branch_target;
                    end else begin
                        r_pc <= pc_plus1;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        // Resume past the halt instruction.
                        r_state       <= S_RUN;
                        r_fetch_valid <= 1'b1;
                        r_pc          <= pc_plus1;
                    end
                end
                default: begin
                    r_state       <= S_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc            = r_pc;
    assign fetch_valid   = r_fetch_valid;
    assign ras_overflow  = r_ras_ovf;
    assign ras_underflow = r_ras_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RPC = 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc, pc_plus1, branch_target, jump_target;
    logic        fetch_valid, stall, branch_taken, jump, call, ret, halt, resume;
    logic        ras_overflow, ras_underflow;

    always #5 clk = ~clk;

    // Behavioural incrementer closing the fetch loop.
    assign pc_plus1 = pc + 32'd1;

    pc_sequencer #(.WIDTH(32), .RESET_PC(RPC), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .pc_plus1(pc_plus1),
        .fetch_valid(fetch_valid), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .call(call), .jump_target(jump_target), .ret(ret),
        .halt(halt), .resume(resume),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    typedef struct {
        logic [31:0] pc;
        logic        fv, ovf, unf;
    } exp_t;

    typedef struct {
        logic [6:0]  c;   // {stall, halt, resume, ret, call, jump, br}
        logic [31:0] jt, bt;
        exp_t        e;
    } vec_t;

    localparam logic [6:0] C_IDLE = 7'd0,  C_BR = 7'd1,    C_JMP = 7'd2, C_CALL = 7'd4;
    localparam logic [6:0] C_RET = 7'd8,   C_RES = 7'd16,  C_HALT = 7'd32, C_STALL = 7'd64;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t V(input logic [6:0] c, input logic [31:0] jt, input logic [31:0] bt,
                               input logic [31:0] epc, input logic fv, input logic ovf,
                               input logic unf);
        vec_t v;
        v.c = c; v.jt = jt; v.bt = bt;
        v.e.pc = epc; v.e.fv = fv; v.e.ovf = ovf; v.e.unf = unf;
        return v;
    endfunction

    task automatic drive(input logic [6:0] c, input logic [31:0] jt, input logic [31:0] bt);
        {stall, halt, resume, ret, call, jump, branch_taken} = c;
        jump_target   = jt;
        branch_target = bt;
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        drive(v.c, v.jt, v.bt);
        exp_q.push_back(v.e);
    endtask

    // Park the DUT on stall and make sure every expectation was consumed.
    task automatic drain();
        int n;
        @(negedge clk);
        drive(C_STALL, 32'h0, 32'h0);
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_pc"},  pc, RPC);
        chk({tag, "_fv"},  {31'd0, fetch_valid}, 0);
        chk({tag, "_ovf"}, {31'd0, ras_overflow}, 0);
        chk({tag, "_unf"}, {31'd0, ras_underflow}, 0);
        chk({tag, "_cnt"}, 32'(dut.r_ras_cnt), 0);
    endtask

    // Release reset at a negedge; the next edge is BOOT->RUN with pc unchanged.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(C_IDLE, 32'h0, 32'h0);
        mon_push(RPC, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic mon_push(input logic [31:0] p, input logic fv, input logic o, input logic u);
        exp_t e;
        e.pc = p; e.fv = fv; e.ovf = o; e.unf = u;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("pc",  pc, mon_e.pc);
                chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, mon_e.fv});
                chk("ras_overflow", {31'd0, ras_overflow}, {31'd0, mon_e.ovf});
                chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, mon_e.unf});
            end
        end
    end

    initial begin
        drive(C_IDLE, 32'h0, 32'h0);
        #12;
        reset_checks("reset");

        // Reset release, sequential run, call/return round trip.
        tbl.push_back(V(C_IDLE, 0, 0, 32'h11, 1, 0, 0));
        tbl.push_back(V(C_IDLE, 0, 0, 32'h12, 1, 0, 0));
        tbl.push_back(V(C_IDLE, 0, 0, 32'h13, 1, 0, 0));
        tbl.push_back(V(C_JMP, 32'h20, 0, 32'h20, 1, 0, 0));
        tbl.push_back(V(C_CALL, 32'h100, 0, 32'h100, 1, 0, 0));
        for (int k = 1; k <= 5; k++) tbl.push_back(V(C_IDLE, 0, 0, 32'h100 + k, 1, 0, 0));
        tbl.push_back(V(C_RET, 0, 0, 32'h21, 1, 0, 0));
        tbl.push_back(V(C_BR, 0, 32'h33, 32'h33, 1, 0, 0));
        tbl.push_back(V(C_JMP | C_BR, 32'h44, 32'h55, 32'h44, 1, 0, 0));
        tbl.push_back(V(C_STALL | C_JMP, 32'h99, 0, 32'h44, 1, 0, 0));
        release_reset();
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        drain();
        chk("cnt_after_ret", 32'(dut.r_ras_cnt), 0);

        // Five nested calls into a 4-deep RAS, then returns down to underflow.
        for (int k = 1; k <= 5; k++) begin
            step(V(C_JMP, k, 0, k, 1, 0, 0));
            step(V(C_CALL, 32'h80, 0, 32'h80, 1, k == 5, 0));
        end
        for (int r = 0; r < 4; r++) begin
            step(V(C_RET, 0, 0, 32'h6 - r, 1, 1, 0));
            step(V(C_JMP, 32'h80, 0, 32'h80, 1, 1, 0));
        end
        step(V(C_RET, 0, 0, 32'h81, 1, 1, 1));
        drain();
        chk("cnt_after_underflow", 32'(dut.r_ras_cnt), 0);

        // Reset clears the sticky flags.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("reset2");
        release_reset();

        // Priority: ret with empty RAS beats jump and branch.
        step(V(C_JMP, 32'h40, 0, 32'h40, 1, 0, 0));
        step(V(C_RET | C_JMP | C_BR, 32'h200, 32'h300, 32'h41, 1, 0, 1));
        // ret+call performs the pop only: RAS stays empty.
        step(V(C_CALL, 32'h60, 0, 32'h60, 1, 0, 1));
        step(V(C_RET | C_CALL, 32'h70, 0, 32'h42, 1, 0, 1));
        drain();
        chk("cnt_ret_call", 32'(dut.r_ras_cnt), 0);

        // Halt deferred by stall, held through toggling controls, then resume.
        step(V(C_JMP, 32'h50, 0, 32'h50, 1, 0, 1));
        step(V(C_STALL | C_HALT, 0, 0, 32'h50, 1, 0, 1));
        step(V(C_HALT, 0, 0, 32'h50, 0, 0, 1));
        for (int k = 0; k < 10; k++) begin
            step(V((k % 2) ? C_JMP : (C_BR | C_RET | C_CALL), 32'h123, 32'h456, 32'h50, 0, 0, 1));
        end
        step(V(C_RES, 0, 0, 32'h51, 1, 0, 1));
        step(V(C_IDLE, 0, 0, 32'h52, 1, 0, 1));

        // Signed wrap is unflagged.
        step(V(C_JMP, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 1, 0, 1));
        step(V(C_IDLE, 0, 0, 32'h8000_0000, 1, 0, 1));
        step(V(C_CALL, 32'h300, 0, 32'h300, 1, 0, 1));
        drain();
        chk("cnt_after_call", 32'(dut.r_ras_cnt), 1);

        // Asynchronous reset in the middle of a call cycle.
        @(negedge clk);
        drive(C_CALL, 32'h400, 0);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("midcall_reset");
        @(posedge clk);
        #1;
        reset_checks("held_reset");
        release_reset();
        step(V(C_RET, 0, 0, RPC + 32'd1, 1, 0, 1));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter sequencer that closes the fetch loop around the combinational PC incrementer. It holds the architectural PC, drives it to the incrementer and instruction memory, and consumes the returned PC+1 to select the next PC. Next-PC sources are sequential, branch, jump, call and return, backed by a small return-address stack (RAS). The block also implements stall, halt and resume control.

## Interface
- WIDTH, 32: PC width; PC values are signed two's complement.
- RESET_PC, 0: PC value loaded at reset.
- RAS_DEPTH, 4: number of return-address stack entries (≥2).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- pc  out  WIDTH  current PC (registered); drives the incrementer and instruction memory
- pc_plus1  in  WIDTH  incrementer result for the current pc (combinational return path)
- fetch_valid  out  1  pc is a valid fetch address this cycle
- stall  in  1  hold pc and the RAS
- branch_taken  in  1  conditional branch resolved taken
- branch_target  in  WIDTH  branch destination
- jump  in  1  unconditional jump
- call  in  1  jump that also pushes pc_plus1 onto the RAS
- jump_target  in  WIDTH  destination for jump and call
- ret  in  1  pop the RAS into pc
- halt  in  1  enter HALT
- resume  in  1  leave HALT
- ras_overflow  out  1  sticky; a push occurred while the RAS was full
- ras_underflow  out  1  sticky; a pop occurred while the RAS was empty

## Operation
- FSM states are BOOT, RUN and HALT.
  - Reset enters BOOT.
  - BOOT → RUN unconditionally after one cycle; pc is unchanged.
  - RUN → HALT when halt=1 and stall=0.
  - HALT → RUN when resume=1.
- In BOOT and HALT, every control input except resume is ignored. pc and the RAS hold.
- Next-PC selection in RUN uses fixed priority, highest first:
  1. stall: pc holds.
  2. halt: pc holds and the FSM moves to HALT.
  3. ret: pc ← top of stack, then pop.
  4. call: push pc_plus1, then pc ← jump_target.
  5. jump: pc ← jump_target.
  6. branch_taken: pc ← branch_target.
  7. Otherwise: pc ← pc_plus1.
- On HALT→RUN, pc ← pc_plus1, so execution resumes after the halt instruction.
- If several controls are asserted together, only the highest-priority one acts. For example, ret and call together perform the pop only; no push occurs.
- RAS behaviour:
  - Count ranges 0..RAS_DEPTH.
  - Push when full discards the oldest entry, keeps count at RAS_DEPTH, and sets ras_overflow.
  - Pop when empty sets ras_underflow, loads pc ← pc_plus1, and leaves count at 0.
- The error flags are cleared only by reset.
- Arithmetic: pc_plus1 is accepted as provided, with no range check. Wrap from 0x7FFFFFFF to 0x80000000 is legal and unflagged.
- fetch_valid = 1 in RUN, 0 in BOOT and HALT.

## Timing
- Reset (asynchronous, immediate on rst_n falling):
  - pc = RESET_PC, FSM = BOOT, RAS count = 0.
  - fetch_valid = 0, ras_overflow = 0, ras_underflow = 0.
  - Entry contents are don't-care.
- Reset asserted mid-operation aborts any in-flight push or pop. The RAS is empty afterward.
- First fetch: fetch_valid rises on the first rising edge after rst_n deasserts, with pc = RESET_PC.
- Control inputs sampled at edge N take effect at edge N; the new pc is visible after edge N.
- Latency is one cycle from a control input to the pc update. RAS push and pop commit on the same edge as the pc update.
- pc_plus1 must settle within the same cycle as pc. No register sits on the incrementer path.
- A stall lasting any number of cycles holds pc, the RAS, FSM state and the flags exactly.
- halt asserted with stall is deferred until stall drops.

## Test plan
- Reset release with RESET_PC=0x10 and no controls:
  - one cycle of pc=0x10 with fetch_valid=0;
  - then pc=0x10 with fetch_valid=1;
  - then 0x11, 0x12, 0x13 on successive cycles.
- At pc=0x20, assert call with jump_target=0x100, then ret at pc=0x105 → pc sequence 0x100…0x105, then 0x21; RAS count returns to 0.
- With RAS_DEPTH=4, perform 5 nested calls from pc=0x1,0x2,0x3,0x4,0x5 (target 0x80 each), then 4 rets:
  - ras_overflow=1;
  - pops return 0x6,0x5,0x4,0x3;
  - a 5th ret sets ras_underflow=1 and gives pc=0x81.
- Priority check: at pc=0x40, assert ret with empty RAS together with jump (target 0x200) and branch_taken (target 0x300) → pc=0x41, ras_underflow=1, no jump.
- halt at pc=0x50 → pc holds 0x50 and fetch_valid=0 for 10 cycles with branch_taken/jump toggling; resume → pc=0x51, fetch_valid=1.
- Wrap and reset mid-run:
  - pc=0x7FFFFFFF, sequential step → pc=0x80000000, no flag;
  - mid-call, assert rst_n=0 asynchronously → pc=RESET_PC immediately, RAS count 0, flags 0.
